// File: rtl/arf_pkg.sv
// Shared types and defaults for the ARF first-layer operand loader.
package arf_pkg;

   localparam int unsigned DATA_W_DEF  = 16;
   localparam int unsigned N_OPS_DEF   = 16;
   localparam int unsigned FRAME_CNT_W = 16;

   typedef enum logic {
      ST_FILL = 1'b0,
      ST_DROP = 1'b1
   } ld_state_e;

   // Index width that stays at least one bit wide for single-entry banks.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/arf_op_bank.sv
// One frame of operand storage: indexed word writes, whole frame read out flat.
module arf_op_bank
   import arf_pkg::*;
#(
   parameter int unsigned  DATA_W = DATA_W_DEF,
   parameter int unsigned  N_OPS  = N_OPS_DEF,
   localparam int unsigned IDX_W  = idx_w(N_OPS)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    wr_en,
   input  logic [IDX_W-1:0]        wr_idx,
   input  logic [DATA_W-1:0]       wr_data,
   output logic [N_OPS*DATA_W-1:0] rd_data
);

   logic [N_OPS-1:0][DATA_W-1:0] mem_q;
   logic [N_OPS-1:0][DATA_W-1:0] mem_d;

   // Decode the write index per slot so out-of-range indices simply write nothing.
   always_comb begin
      mem_d = mem_q;
      for (int k = 0; k < N_OPS; k++) begin
         if (wr_en && (wr_idx == IDX_W'(k))) begin
            mem_d[k] = wr_data;
         end
      end
   end

   // Storage register; cleared on reset so the parallel output reads zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '0;
      end else begin
         mem_q <= mem_d;
      end
   end

   assign rd_data = mem_q;

endmodule

// File: rtl/arf_operand_loader.sv
// Serial-to-parallel operand loader feeding the ARF first-layer multipliers.
// Two ping-pong banks: one fills from the serial stream while the other is
// presented to the datapath. Malformed frames are flagged and discarded.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   ST_FILL | storing words into bank wptr at index wcnt
//   ST_DROP | frame overran N_OPS; swallow words until in_last
module arf_operand_loader
   import arf_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned N_OPS  = N_OPS_DEF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DATA_W-1:0]       in_data,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [N_OPS*DATA_W-1:0] out_ops,
   output logic                    err_short,
   output logic                    err_long,
   output logic [FRAME_CNT_W-1:0]  frame_cnt
);

   localparam int unsigned IDX_W = idx_w(N_OPS);

   ld_state_e              state_q, state_d;
   logic                   wptr_q, wptr_d;
   logic                   rptr_q, rptr_d;
   logic [1:0]             full_q, full_d;
   logic [IDX_W-1:0]       wcnt_q, wcnt_d;
   logic                   err_short_q, err_short_d;
   logic                   err_long_q, err_long_d;
   logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
   logic                   rdy_en_q, rdy_en_d;

   logic                    accept;
   logic                    consume;
   logic                    at_end;
   logic [1:0]              bank_we;
   logic [N_OPS*DATA_W-1:0] bank0_rd;
   logic [N_OPS*DATA_W-1:0] bank1_rd;

   // rdy_en_q holds in_ready low through reset and releases it one edge later.
   assign in_ready  = rdy_en_q & ((state_q == ST_DROP) | ~full_q[wptr_q]);
   assign out_valid = full_q[rptr_q];
   assign out_ops   = rptr_q ? bank1_rd : bank0_rd;
   assign err_short = err_short_q;
   assign err_long  = err_long_q;
   assign frame_cnt = frame_cnt_q;

   assign accept  = in_valid & in_ready;
   assign consume = out_valid & out_ready;
   assign at_end  = (wcnt_q == IDX_W'(N_OPS - 1));

   // Next-state: fill/drop sequencing and bank hand-off. Fill and consume touch
   // different banks (filling needs the bank empty, consuming needs it full),
   // so both may update full_d in the same cycle.
   always_comb begin
      state_d     = state_q;
      wptr_d      = wptr_q;
      rptr_d      = rptr_q;
      full_d      = full_q;
      wcnt_d      = wcnt_q;
      err_short_d = 1'b0;
      err_long_d  = 1'b0;
      frame_cnt_d = frame_cnt_q;
      rdy_en_d    = 1'b1;
      bank_we     = 2'b00;

      if (consume) begin
         full_d[rptr_q] = 1'b0;
         rptr_d         = ~rptr_q;
         frame_cnt_d    = frame_cnt_q + FRAME_CNT_W'(1);
      end

      unique case (state_q)
         ST_FILL: begin
            if (accept) begin
               // A write into a frame that later turns out bad is harmless:
               // the bank is only marked full on a well-formed last word.
               bank_we[wptr_q] = 1'b1;
               if (in_last && at_end) begin
                  full_d[wptr_q] = 1'b1;
                  wptr_d         = ~wptr_q;
                  wcnt_d         = '0;
               end else if (in_last) begin
                  err_short_d = 1'b1;
                  wcnt_d      = '0;
               end else if (at_end) begin
                  err_long_d = 1'b1;
                  wcnt_d     = '0;
                  state_d    = ST_DROP;
               end else begin
                  wcnt_d = wcnt_q + IDX_W'(1);
               end
            end
         end
         ST_DROP: begin
            if (accept && in_last) begin
               state_d = ST_FILL;
               wcnt_d  = '0;
            end
         end
         default: begin
            state_d = ST_FILL;
         end
      endcase
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_FILL;
         wptr_q      <= 1'b0;
         rptr_q      <= 1'b0;
         full_q      <= 2'b00;
         wcnt_q      <= '0;
         err_short_q <= 1'b0;
         err_long_q  <= 1'b0;
         frame_cnt_q <= '0;
         rdy_en_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         full_q      <= full_d;
         wcnt_q      <= wcnt_d;
         err_short_q <= err_short_d;
         err_long_q  <= err_long_d;
         frame_cnt_q <= frame_cnt_d;
         rdy_en_q    <= rdy_en_d;
      end
   end

   arf_op_bank #(
      .DATA_W (DATA_W),
      .N_OPS  (N_OPS)
   ) u_bank0 (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (bank_we[0]),
      .wr_idx  (wcnt_q),
      .wr_data (in_data),
      .rd_data (bank0_rd)
   );

   arf_op_bank #(
      .DATA_W (DATA_W),
      .N_OPS  (N_OPS)
   ) u_bank1 (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (bank_we[1]),
      .wr_idx  (wcnt_q),
      .wr_data (in_data),
      .rd_data (bank1_rd)
   );

endmodule

// File: doc/arf_operand_loader.md
ARF_OPERAND_LOADER -- requirements
Module: arf_operand_loader

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, operand width in bits.
REQ-002 The block SHALL have parameter N_OPS, default 16, operands per frame: the 8 multiplier pairs of the ARF first layer.
REQ-003 The block SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port in_valid  input  1  serial operand word valid.
REQ-006 The block SHALL have port in_ready  output  1  loader accepts word this cycle.
REQ-007 The block SHALL have port in_data  input  DATA_W  operand word.
REQ-008 The block SHALL have port in_last  input  1  final word of frame.
REQ-009 The block SHALL have port out_valid  output  1  complete frame presented.
REQ-010 The block SHALL have port out_ready  input  1  ARF datapath consumes frame.
REQ-011 The block SHALL have port out_ops  output  N_OPS*DATA_W  parallel operands; slice k = word k of frame; word 2m+j feeds multiplier m+1, input j.
REQ-012 The block SHALL have port err_short  output  1  one-cycle pulse, frame ended early.
REQ-013 The block SHALL have port err_long  output  1  one-cycle pulse, frame overran N_OPS.
REQ-014 The block SHALL have port frame_cnt  output  16  frames delivered, modulo 2^16.

Function
REQ-015 Two storage banks SHALL be used ping-pong; each bank has a full flag; fill pointer wptr and read pointer rptr are 1 bit each.
REQ-016 A word SHALL be accepted iff in_valid && in_ready; accepted word stored at index wcnt of bank wptr; wcnt increments.
REQ-017 FSM states SHALL be FILL and DROP; reset state FILL.
REQ-018 In FILL, in_ready SHALL equal !full[wptr]; in DROP, in_ready SHALL be 1.
REQ-019 Accepted word with in_last and wcnt==N_OPS-1 SHALL set full[wptr], toggle wptr, clear wcnt.
REQ-020 Accepted word with in_last and wcnt<N_OPS-1 SHALL pulse err_short next cycle, clear wcnt, leave bank empty, stay in FILL.
REQ-021 Accepted word with !in_last and wcnt==N_OPS-1 SHALL pulse err_long next cycle, clear wcnt, discard bank, enter DROP.
REQ-022 In DROP, accepted words SHALL be discarded; accepted word with in_last SHALL return FSM to FILL with wcnt=0.
REQ-023 out_valid SHALL equal full[rptr]; out_ops SHALL be bank rptr contents, stable while out_valid && !out_ready.
REQ-024 out_valid && out_ready SHALL clear full[rptr], toggle rptr, increment frame_cnt (wrap 0xFFFF->0x0000).
REQ-025 Latency: last word accepted at edge t SHALL give out_valid high after edge t when bank rptr==bank just filled.
REQ-026 Bank freed at edge t SHALL make in_ready high after edge t (no combinational out_ready->in_ready path).
REQ-027 Frame completion and frame consumption in the same cycle SHALL both take effect; no word or frame lost.
REQ-028 Both banks full SHALL hold in_ready low; in_data ignored.

Reset
REQ-029 rst_n low SHALL immediately force in_ready=0, out_valid=0, out_ops=0, err_short=0, err_long=0, frame_cnt=0, full flags 0, wptr=rptr=0, wcnt=0, FSM FILL.
REQ-030 Reset mid-frame SHALL discard partial and held frames; in_ready=1 on first edge after rst_n deasserts.

Structure
REQ-031 Package arf_pkg SHALL hold DATA_W/N_OPS defaults, the FSM state enum, and the frame_cnt width constant.
REQ-032 One sub-module arf_op_bank (N_OPS x DATA_W register bank, write-enable plus index, flat read-out) SHALL be instantiated twice.

Verification
REQ-033 Words 0x0001..0x0010, in_last on 16th, out_ready=1 -> out_valid one cycle after 16th accept, slice0=0x0001, slice15=0x0010, frame_cnt=1.
REQ-034 Three back-to-back frames, out_ready=0 -> in_ready low after second frame; raise out_ready -> frames delivered in order, frame_cnt=3.
REQ-035 in_last on 5th word -> err_short pulse one cycle, no out_valid; next 16-word frame delivered intact.
REQ-036 20-word frame, in_last on 20th -> err_long pulse after 16th word, words 17-20 dropped, no out_valid; next frame intact.
REQ-037 rst_n low after word 8 of a frame with one frame held -> all outputs 0 asynchronously; clean frame afterwards gives frame_cnt=1.
REQ-038 frame_cnt preloaded by 65535 deliveries, one more frame -> frame_cnt=0x0000.
